// File: rtl/instr_prefetch_unit.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue feeding the decoder.
// Optional same-cycle bypass of an empty queue is enabled by defining PREFETCH_BYPASS_EN.
module instr_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000000000000000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [63:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_pc,
    input  logic                       redirect_en,
    input  logic [63:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   fpc;
    logic [63:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic fetch_done;
    logic q_valid;
    logic push;
    logic pop;
    logic pop_q;
`ifdef PREFETCH_BYPASS_EN
    logic bypass;
`endif

    always_comb begin
        imem_req   = !rst && !redirect_en && (count < FULL);
        fetch_done = imem_req && imem_ack;
        q_valid    = (count != '0);
`ifdef PREFETCH_BYPASS_EN
        // An empty queue lets the word just returned go straight to the decoder.
        bypass     = fetch_done && !q_valid;
        out_valid  = q_valid || bypass;
        if (q_valid) begin
            out_instr = q_instr[rd_ptr];
            out_pc    = q_pc[rd_ptr];
        end else if (bypass) begin
            out_instr = imem_rdata;
            out_pc    = fpc;
        end else begin
            out_instr = '0;
            out_pc    = '0;
        end
        pop        = out_valid && out_ready && !redirect_en;
        push       = fetch_done && !(bypass && out_ready);
`else
        out_valid  = q_valid;
        out_instr  = q_valid ? q_instr[rd_ptr] : '0;
        out_pc     = q_valid ? q_pc[rd_ptr] : '0;
        pop        = out_valid && out_ready && !redirect_en;
        push       = fetch_done;
`endif
        pop_q      = pop && q_valid;
    end

    assign imem_addr = fpc;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_en) begin
            fpc    <= {redirect_pc[63:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch_done) begin
                fpc <= fpc + 64'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop_q})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries no reset; push is already blocked during rst and redirect.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= fpc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit (default build, bypass disabled).
module tb_instr_prefetch_unit;
    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, out_valid, out_ready, redirect_en;
    logic [63:0] imem_addr, out_pc, redirect_pc;
    logic [31:0] imem_rdata, out_instr;
    logic [2:0]  occupancy;

    int vec  = 0;
    int errs = 0;

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = mem_fn(imem_addr);

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected {pc, instr} entries in fetch order.
    logic [95:0] sb[$];
    logic [63:0] model_fpc = '0;
    bit          model_ok  = 1'b0;
    int          cnt_pre   = 0;

    // Model: predicts each clock edge from the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            model_fpc = RPC;
            model_ok  = 1'b1;
        end else if (redirect_en) begin
            sb.delete();
            model_fpc = {redirect_pc[63:2], 2'b00};
        end else if (model_ok && cnt_pre < DEPTH && imem_ack) begin
            sb.push_back({model_fpc, mem_fn(model_fpc)});
            model_fpc = model_fpc + 64'd4;
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires consumed entries.
    always @(negedge clk) begin
        if (model_ok) begin
            cnt_pre = sb.size();
            check("occupancy", 96'(occupancy), 96'(cnt_pre));
            check("out_valid", 96'(out_valid), 96'(cnt_pre != 0));
            check("imem_req", 96'(imem_req), 96'(!rst && !redirect_en && cnt_pre < DEPTH));
            check("imem_addr", 96'(imem_addr), 96'(model_fpc));
            if (cnt_pre != 0) begin
                check("head", {out_pc, out_instr}, sb[0]);
                if (out_ready && !redirect_en && !rst) begin
                    void'(sb.pop_front());
                end
            end else begin
                check("empty_out", {out_pc, out_instr}, 96'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b1; out_ready = 1'b1;
        redirect_en = 1'b0; redirect_pc = '0;
        step(); step();

        // Streaming from reset: 1000, 1004, 1008 ... each seen at the output a cycle later.
        rst = 1'b0;
        mid(); check("addr0", 96'(imem_addr), 96'h1000);
        step(); mid(); check("addr1", 96'(imem_addr), 96'h1004);
        check("pc0", 96'(out_pc), 96'h1000);
        step(); mid(); check("addr2", 96'(imem_addr), 96'h1008);
        check("pc1", 96'(out_pc), 96'h1004);
        repeat (3) step();

        // Backpressure directly after reset.
        rst = 1'b1; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (4) step();
        mid();
        check("bp_occ", 96'(occupancy), 96'd4);
        check("bp_req", 96'(imem_req), 96'd0);
        check("bp_addr", 96'(imem_addr), 96'h1010);
        check("bp_head", 96'(out_pc), 96'h1000);
        out_ready = 1'b1;
        step(); out_ready = 1'b0;
        mid();
        check("bp_refetch_req", 96'(imem_req), 96'd1);
        check("bp_refetch_addr", 96'(imem_addr), 96'h1010);
        step(); mid();
        check("bp_full_again", 96'(imem_req), 96'd0);
        check("bp_next_addr", 96'(imem_addr), 96'h1014);

        // Redirect with three queued entries and a coinciding pop.
        out_ready = 1'b1; imem_ack = 1'b0;
        step();
        redirect_en = 1'b1; redirect_pc = 64'h2002; imem_ack = 1'b1;
        mid(); check("rd_occ3", 96'(occupancy), 96'd3);
        step();
        redirect_en = 1'b0;
        mid();
        check("rd_occ0", 96'(occupancy), 96'd0);
        check("rd_valid", 96'(out_valid), 96'd0);
        check("rd_req", 96'(imem_req), 96'd1);
        check("rd_addr", 96'(imem_addr), 96'h2000);
        step(); mid();
        check("rd_first_pc", 96'(out_pc), 96'h2000);

        // Random ack/ready with occasional redirects.
        for (int i = 0; i < 2000; i++) begin
            step();
            imem_ack    = 1'($urandom_range(0, 1));
            out_ready   = 1'($urandom_range(0, 1));
            redirect_en = ($urandom_range(0, 63) == 0);
            redirect_pc = {$urandom, $urandom};
        end
        step();
        redirect_en = 1'b0;

        // 64-bit address wrap; pointers wrap over many pushes.
        redirect_en = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; imem_ack = 1'b1; out_ready = 1'b0;
        step();
        redirect_en = 1'b0;
        mid(); check("wrap_addr_top", 96'(imem_addr), 96'hFFFF_FFFF_FFFF_FFFC);
        step(); mid(); check("wrap_addr_zero", 96'(imem_addr), 96'h0);
        check("wrap_head", 96'(out_pc), 96'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 40; i++) begin
            step();
            imem_ack  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
        end
        step();
        imem_ack = 1'b0; out_ready = 1'b1;
        repeat (6) step();

        // Reset while full with ack high.
        imem_ack = 1'b1; out_ready = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        mid();
        check("rst_valid", 96'(out_valid), 96'd0);
        check("rst_occ", 96'(occupancy), 96'd0);
        check("rst_req", 96'(imem_req), 96'd0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        mid(); check("rst_resume_addr", 96'(imem_addr), 96'h1000);
        step(); mid();
        check("rst_resume_pc", 96'(out_pc), 96'h1000);
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction fetch stage with a small prefetch queue, placed directly upstream of the single-cycle decode/execute datapath. It owns the fetch PC and issues sequential word fetches to instruction memory over a req/ack handshake. It buffers returned words with their PCs and hands {pc, instr} pairs to the decoder over a valid/ready interface. A taken branch or jump from the datapath flushes the queue and restarts fetching at the target address.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 64'h0000000000000000, fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  64  fetch address, word aligned
- imem_ack  in  1  memory completes the fetch this cycle; imem_rdata valid
- imem_rdata  in  32  fetched instruction word
- out_valid  out  1  head entry available to decoder
- out_ready  in  1  decoder consumes head this cycle
- out_instr  out  32  instruction at head
- out_pc  out  64  PC of out_instr
- redirect_en  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  64  new fetch address
- occupancy  out  $clog2(DEPTH)+1  current queue entry count

## Operation
- State:
  - fetch PC register fpc (64 bits);
  - circular queue of DEPTH entries, each {pc[63:0], instr[31:0]};
  - read pointer and write pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count, 0..DEPTH.
- Request: imem_req = !rst && !redirect_en && (count < DEPTH). imem_addr = fpc at all times.
  - Memory may hold imem_ack low any number of cycles.
  - The fetch completes on the cycle where imem_req && imem_ack.
  - imem_req must not depend combinationally on out_ready.
- Push: on a completed fetch, write {fpc, imem_rdata} at the write pointer, then advance the write pointer and set fpc <= fpc + 4. Address arithmetic is modulo 2^64.
- Pop: occurs when out_valid && out_ready; advances the read pointer.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop in the same cycle: unchanged. This is legal at any count < DEPTH, including count = 0 when bypass is enabled.
- Full (count == DEPTH): imem_req low; a pop that cycle re-enables imem_req on the next cycle.
- Empty (count == 0): out_valid low (except bypass, see Configuration); out_instr = 0, out_pc = 0.
- Redirect (redirect_en high), which takes priority over everything else that cycle:
  - imem_req low;
  - any pop is discarded (the decoder must not treat the head as consumed);
  - pointers and count cleared;
  - fpc <= {redirect_pc[63:2], 2'b00}. Low two bits are ignored.
- Reset: fpc <= RESET_PC; pointers and count <= 0. Queue data need not be cleared.
- Reset value of every output:
  - imem_req 0 during reset;
  - imem_addr RESET_PC from the first cycle after reset;
  - out_valid 0, out_instr 0, out_pc 0, occupancy 0.
- rst asserted mid-fetch: the outstanding request is abandoned, and an imem_ack in that cycle is ignored.

## Timing
- Fetch-to-output latency (bypass off): a word acked in cycle N has out_valid in cycle N+1.
- Steady state: with imem_ack tied high and out_ready high, one instruction per cycle.
- Redirect in cycle N:
  - out_valid is 0 in cycle N+1;
  - imem_req is high in N+1 with imem_addr = aligned redirect_pc;
  - the first new instruction is on the output in N+2 (bypass off) or N+1 (bypass on, with ack in N+1).
- occupancy is registered and reflects count after the previous edge.
- out_instr, out_pc and out_valid hold stable while out_valid && !out_ready, unless a redirect occurs.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - when count == 0 and a fetch completes, the fetched word and fpc drive out_instr/out_pc combinationally and out_valid is high in the same cycle;
  - if out_ready is also high, the word is not written to the queue;
  - otherwise it is pushed normally;
  - bypass is suppressed during redirect and reset.
- PREFETCH_BYPASS_EN undefined: all outputs come from queue state only; there is no combinational path from imem_* to out_*.

## Test plan
- Reset release with RESET_PC = 64'h1000, imem_ack = 1, out_ready = 1:
  - imem_addr sequence 1000, 1004, 1008 on consecutive cycles;
  - out_pc follows one cycle later with matching out_instr (bypass off).
- Backpressure with out_ready = 0, ack always high, DEPTH = 4:
  - exactly 4 fetches (occupancy 0..4), then imem_req low;
  - raising out_ready for one cycle pops entry 1000 and causes exactly one more fetch at 1010.
- Redirect to 64'h2002 while the queue holds 3 entries and a pop coincides:
  - occupancy becomes 0;
  - the next imem_addr is 2000;
  - the first out_pc is 2000, not the discarded head.
- Random imem_ack (around 50%) and random out_ready over 2000 cycles:
  - out_pc strictly sequential by +4 between redirects;
  - out_instr matches a memory model;
  - no lost or duplicated words.
- Wrap-around with fpc = 64'hFFFF_FFFF_FFFF_FFFC:
  - the next fetch address is 0;
  - pointers wrap across 3*DEPTH pushes without corruption.
- rst asserted mid-stream with a full queue and ack high:
  - the next cycle shows out_valid 0, occupancy 0 and imem_req 0;
  - fetching resumes from RESET_PC after rst falls.
